// File: rtl/uart_prog_loader.sv
// UART (8N1) boot-image loader: packs received bytes into little-endian words,
// writes them to instruction memory and holds the core in reset until the end marker.
module uart_prog_loader #(
  parameter int          CLKS_PER_BIT = 347,
  parameter int          ADDR_W       = 12,
  parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              rx_serial,
  output logic              loader_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              prog_done,
  output logic              frame_err,
  output logic              overflow
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  BIT_HALF  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP} rx_state_e;

  rx_state_e         state_q;
  logic              sync1_q, sync2_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q, byte_q;
  logic              byte_valid_q, frame_bad_q;

  logic [1:0]        bcnt_q;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              full_q, mem_we_q, core_rst_q, prog_done_q;
  logic              frame_err_q, overflow_q, loader_ready_q;

  // Two-flop synchroniser; idles high so reset cannot fake a start bit
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_serial;
      sync2_q <= sync1_q;
    end
  end

  // Receive FSM: start-bit check at half a bit, then one sample per bit time
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= 3'd0;
      shift_q      <= 8'd0;
      byte_q       <= 8'd0;
      byte_valid_q <= 1'b0;
      frame_bad_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_bad_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!sync2_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
          end
        end
        S_START: begin
          if (cnt_q == BIT_HALF) begin
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            state_q <= sync2_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_CLEANUP;
            if (sync2_q) begin
              byte_valid_q <= 1'b1;
              byte_q       <= shift_q;
            end else begin
              frame_bad_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_CLEANUP: begin
          if (sync2_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Drop the incoming byte into its little-endian slot of the word being built
  always_comb begin
    word_d = word_q;
    case (bcnt_q)
      2'd0:    word_d[7:0]   = byte_q;
      2'd1:    word_d[15:8]  = byte_q;
      2'd2:    word_d[23:16] = byte_q;
      2'd3:    word_d[31:24] = byte_q;
      default: word_d        = word_q;
    endcase
  end

  // Word assembly, memory write and loader status; frozen once the marker is seen
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bcnt_q         <= 2'd0;
      word_q         <= 32'd0;
      addr_q         <= '0;
      full_q         <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= 32'd0;
      core_rst_q     <= 1'b1;
      prog_done_q    <= 1'b0;
      frame_err_q    <= 1'b0;
      overflow_q     <= 1'b0;
      loader_ready_q <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (!prog_done_q) begin
        loader_ready_q <= 1'b1;
        if (frame_bad_q) frame_err_q <= 1'b1;
        if (byte_valid_q) begin
          if (bcnt_q == 2'd3) begin
            bcnt_q <= 2'd0;
            word_q <= 32'd0;
            if (word_d == END_WORD) begin
              prog_done_q    <= 1'b1;
              core_rst_q     <= 1'b0;
              loader_ready_q <= 1'b0;
            end else if (!full_q) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= addr_q;
              mem_wdata_q <= word_d;
              // Saturate at the top address instead of wrapping
              if (addr_q == ADDR_LAST) full_q <= 1'b1;
              else                     addr_q <= addr_q + ADDR_ONE;
            end else begin
              overflow_q <= 1'b1;
            end
          end else begin
            bcnt_q <= bcnt_q + 2'd1;
            word_q <= word_d;
          end
        end
      end else begin
        loader_ready_q <= 1'b0;
      end
    end
  end

  assign loader_ready = loader_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign core_rst     = core_rst_q;
  assign prog_done    = prog_done_q;
  assign frame_err    = frame_err_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader (8 clocks per bit, 4-word memory).
module tb_uart_prog_loader;

  localparam int CPB = 8;
  localparam int AW  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic          loader_ready, mem_we, core_rst, prog_done, frame_err, overflow;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .END_WORD(32'h0000_0FFF)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .rx_serial   (rx),
    .loader_ready(loader_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .core_rst    (core_rst),
    .prog_done   (prog_done),
    .frame_err   (frame_err),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Write monitor: logs every strobe and flags back-to-back strobes
  int          wr_cnt = 0;
  logic [31:0] wr_addr [32];
  logic [31:0] wr_data [32];
  logic        prev_we = 1'b0;
  logic        b2b     = 1'b0;
  always @(negedge clk) begin
    if (mem_we) begin
      if (wr_cnt < 32) begin
        wr_addr[wr_cnt] = 32'(mem_addr);
        wr_data[wr_cnt] = mem_wdata;
      end
      wr_cnt++;
    end
    if (mem_we && prev_we) b2b = 1'b1;
    prev_we = mem_we;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  int base;

  initial begin
    // Reset values while reset is held
    repeat (3) @(negedge clk);
    check("rst_core_rst",  32'(core_rst),     32'd1);
    check("rst_ready",     32'(loader_ready), 32'd0);
    check("rst_we",        32'(mem_we),       32'd0);
    check("rst_done",      32'(prog_done),    32'd0);
    check("rst_ferr",      32'(frame_err),    32'd0);
    check("rst_ovf",       32'(overflow),     32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("ready_after_rst", 32'(loader_ready), 32'd1);

    // Two instruction words then the end marker
    base = wr_cnt;
    send_word(32'h0000_0013);
    check("w0_cnt",  32'(wr_cnt - base), 32'd1);
    check("w0_addr", wr_addr[base],      32'd0);
    check("w0_data", wr_data[base],      32'h0000_0013);
    check("w0_core_rst", 32'(core_rst),  32'd1);
    send_word(32'h0010_0093);
    check("w1_cnt",  32'(wr_cnt - base), 32'd2);
    check("w1_addr", wr_addr[base+1],    32'd1);
    check("w1_data", wr_data[base+1],    32'h0010_0093);
    send_word(32'h0000_0FFF);
    check("end_cnt",      32'(wr_cnt - base), 32'd2);
    check("end_done",     32'(prog_done),     32'd1);
    check("end_core_rst", 32'(core_rst),      32'd0);
    check("end_ready",    32'(loader_ready),  32'd0);

    // Traffic after completion is ignored
    send_word(32'h0000_0013);
    check("post_cnt",      32'(wr_cnt - base), 32'd2);
    check("post_addr",     32'(mem_addr),      32'd1);
    check("post_done",     32'(prog_done),     32'd1);
    check("post_core_rst", 32'(core_rst),      32'd0);
    check("post_ferr",     32'(frame_err),     32'd0);
    check("post_ovf",      32'(overflow),      32'd0);

    // Frame error does not consume a byte slot
    do_reset();
    base = wr_cnt;
    send_byte(8'h55, 1'b0);
    check("ferr_set",  32'(frame_err),     32'd1);
    check("ferr_nowr", 32'(wr_cnt - base), 32'd0);
    send_word(32'h0403_0201);
    check("ferr_cnt",  32'(wr_cnt - base), 32'd1);
    check("ferr_addr", wr_addr[base],      32'd0);
    check("ferr_data", wr_data[base],      32'h0403_0201);

    // Short low glitch on idle line is rejected
    do_reset();
    base = wr_cnt;
    @(negedge clk) rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    send_word(32'h0000_00A5);
    check("glitch_ferr", 32'(frame_err),     32'd0);
    check("glitch_cnt",  32'(wr_cnt - base), 32'd1);
    check("glitch_addr", wr_addr[base],      32'd0);
    check("glitch_data", wr_data[base],      32'h0000_00A5);

    // Address space of 4 words: fifth word overflows, marker still completes
    do_reset();
    base = wr_cnt;
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    send_word(32'h3333_3333);
    send_word(32'h4444_4444);
    check("full_cnt",   32'(wr_cnt - base), 32'd4);
    check("full_a0",    wr_addr[base],      32'd0);
    check("full_a3",    wr_addr[base+3],    32'd3);
    check("full_d3",    wr_data[base+3],    32'h4444_4444);
    check("full_noovf", 32'(overflow),      32'd0);
    send_word(32'h5555_5555);
    check("ovf_set",  32'(overflow),      32'd1);
    check("ovf_nowr", 32'(wr_cnt - base), 32'd4);
    send_word(32'h0000_0FFF);
    check("ovf_done", 32'(prog_done),     32'd1);
    check("ovf_cnt",  32'(wr_cnt - base), 32'd4);

    // Reset mid-word discards the partial word
    do_reset();
    base = wr_cnt;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("mid_rst_core", 32'(core_rst), 32'd1);
    repeat (2) @(negedge clk);
    send_word(32'hDEAD_BEEF);
    check("mid_cnt",  32'(wr_cnt - base), 32'd1);
    check("mid_addr", wr_addr[base],      32'd0);
    check("mid_data", wr_data[base],      32'hDEAD_BEEF);
    check("mid_core", 32'(core_rst),      32'd1);
    send_word(32'h0000_0FFF);
    check("mid_end_core", 32'(core_rst),  32'd0);

    check("no_b2b_we", 32'(b2b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- UART receive-side program loader inside the user project area.
- Deserialises the boot image sent by the bench/host UART programmer on the serial input pin (mprj_io[5]). Packs the bytes into 32-bit little-endian words and writes them sequentially into the core instruction memory.
- Holds the BrqRV core in reset until an end-of-program marker word arrives, then releases it.
- Drives a ready indication (routed to mprj_io[37]) telling the programmer to start sending.

Parameters:
- CLKS_PER_BIT, 347, clock cycles per UART bit (40 MHz / 115200); must be >= 4
- ADDR_W, 12, word-address width of instruction memory
- END_WORD, 32'h0000_0FFF, marker word that ends loading; never written to memory

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- rx_serial  in  1  UART RX line, idle high, 8N1, LSB first
- loader_ready  out  1  high while awaiting/receiving image
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  ADDR_W  word address of write
- mem_wdata  out  32  write data
- core_rst  out  1  active-high reset to core; high until load done
- prog_done  out  1  sticky, end marker received
- frame_err  out  1  sticky, stop bit sampled low
- overflow  out  1  sticky, word arrived after address space full

Behaviour:
- Reset: all outputs 0 except core_rst=1. Word address=0, byte count=0, RX FSM=IDLE, synchroniser flops=1.
- loader_ready=1 from the first cycle after reset deassertion until prog_done; 0 afterwards.
- rx_serial passes through a 2-flop synchroniser; all sampling uses the synchronised value (rxs).
- RX FSM states and transitions:
  - IDLE: rxs==0 -> START, clear bit-time counter.
  - START: at count CLKS_PER_BIT/2 (integer) re-sample. If rxs==0 -> DATA with counter cleared; else glitch, return to IDLE with no flags set.
  - DATA: every CLKS_PER_BIT cycles sample one bit into the shift register, LSB first. After the 8th bit -> STOP.
  - STOP: after CLKS_PER_BIT cycles sample the stop bit.
    - rxs==1: byte_valid pulses 1 cycle.
    - rxs==0: frame_err<=1, byte discarded, byte count unchanged.
    - Either way -> CLEANUP.
  - CLEANUP: wait until rxs==1, then -> IDLE. A held-low line cannot retrigger.
- Word assembly:
  - Byte k (k=0..3) goes to bits [8k+7:8k].
  - On the 4th valid byte the word is complete and the byte count returns to 0.
- Write, same cycle after word completion (1 cycle after the 4th byte_valid):
  - word==END_WORD: no write; prog_done<=1, core_rst<=0 on that same edge.
  - else if address not full: mem_we=1, mem_addr=current address, mem_wdata=word; address increments on that edge.
  - else: overflow<=1, word dropped, no write.
- Address full: after the write to address 2^ADDR_W-1 the address does not wrap. A full flag is set, and all further words raise overflow.
- After prog_done: RX FSM keeps running but bytes are ignored. No mem_we, no flag changes, core_rst stays 0 until wb_rst_i.
- mem_we is never asserted in two consecutive cycles; at most one write per 4 UART frames.
- wb_rst_i mid-frame or mid-word: everything returns to reset values the next edge. The partial word is discarded; the loader restarts at address 0 and core_rst returns to 1.
- A frame error mid-word does not realign the word. Byte count is unchanged, so the next good byte fills the same slot.

Test Plan:
- CLKS_PER_BIT=8. Send bytes 13,00,00,00, 93,00,10,00, FF,0F,00,00 -> mem_we at addr 0 data 0x00000013, addr 1 data 0x00100093. Then prog_done=1, core_rst=0, loader_ready=0; exactly 2 writes.
- Send 0x55 with stop bit driven low, then 4 valid bytes 01,02,03,04 -> frame_err=1; write addr 0 data 0x04030201.
- 2-cycle low glitch on idle line, then a valid frame 0xA5 -> glitch ignored, no frame_err, byte assembled as 0xA5.
- ADDR_W=2: send 5 non-marker words -> writes to addrs 0..3; 5th raises overflow with no mem_we; then END_WORD -> prog_done=1.
- Send 2 bytes, assert wb_rst_i 1 cycle, then a full word 0xDEADBEEF -> written at addr 0 as 0xDEADBEEF; core_rst=1 during and after reset until the marker.
- After prog_done, send 0x00000013 -> no mem_we, address and flags unchanged.
